// File: rtl/intersection_scheduler.sv
// intersection_scheduler: main/side road signal controller with pedestrian phase.
// Main road rests green; a side-road or pedestrian request is served after the
// minimum main green, going through yellow and all-red clearance each way.
// When both are pending, service alternates, with side first after reset.
// Optional build macro EMERGENCY_PREEMPT_EN adds the emerg input. While emerg is
// high, side green and walk are cut short, the main road is held green, and
// preempted requests stay pending.

module intersection_scheduler #(
   parameter int MAIN_MIN_GREEN = 20,
   parameter int SIDE_GREEN     = 15,
   parameter int YELLOW         = 5,
   parameter int ALL_RED        = 2,
   parameter int WALK           = 10,
   parameter int PED_CLEAR      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       side_req,
   input  logic       ped_req,
`ifdef EMERGENCY_PREEMPT_EN
   input  logic       emerg,
`endif
   output logic       m_red,
   output logic       m_yellow,
   output logic       m_green,
   output logic       s_red,
   output logic       s_yellow,
   output logic       s_green,
   output logic       walk,
   output logic       dont_walk,
   output logic       side_ack,
   output logic       ped_ack,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      MAIN_G   = 3'd0,
      MAIN_Y   = 3'd1,
      AR1      = 3'd2,
      SIDE_G   = 3'd3,
      SIDE_Y   = 3'd4,
      PED_WALK = 3'd5,
      PED_CLR  = 3'd6,
      AR2      = 3'd7
   } state_t;

   typedef enum logic {
      SRV_SIDE = 1'b0,
      SRV_PED  = 1'b1
   } served_t;

   // Last timer value of each timed phase: the phase lasts exactly DUR cycles.
   localparam logic [7:0] MIN_G_LAST  = 8'(MAIN_MIN_GREEN - 1);
   localparam logic [7:0] SIDE_G_LAST = 8'(SIDE_GREEN - 1);
   localparam logic [7:0] YEL_LAST    = 8'(YELLOW - 1);
   localparam logic [7:0] AR_LAST     = 8'(ALL_RED - 1);
   localparam logic [7:0] WALK_LAST   = 8'(WALK - 1);
   localparam logic [7:0] PCLR_LAST   = 8'(PED_CLEAR - 1);

   state_t     state;
   state_t     nxt;
   logic [7:0] timer;
   logic       pend_side;
   logic       pend_ped;
   served_t    last_served;
   logic       emg;
   logic       enter_side;
   logic       enter_ped;

`ifdef EMERGENCY_PREEMPT_EN
   assign emg = emerg;
`else
   assign emg = 1'b0;
`endif

   assign enter_side = (nxt == SIDE_G) && (state != SIDE_G);
   assign enter_ped  = (nxt == PED_WALK) && (state != PED_WALK);

   // State, phase timer, request latches and grant pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= MAIN_G;
         timer       <= 8'd0;
         pend_side   <= 1'b0;
         pend_ped    <= 1'b0;
         last_served <= SRV_PED;
         side_ack    <= 1'b0;
         ped_ack     <= 1'b0;
      end else begin
         state <= nxt;

         // Timer restarts on every state change and saturates at 255 (only
         // the open-ended main green can get that far).
         if (nxt != state)
            timer <= 8'd0;
         else if (timer != 8'hFF)
            timer <= timer + 8'd1;

         // A preempted grant is handed back as pending. Otherwise the entry
         // clear beats a request in the same cycle. During emerg a grant never
         // clears its flag, because that grant is about to be cut short.
         if (emg && state == SIDE_G)
            pend_side <= 1'b1;
         else if (enter_side && !emg)
            pend_side <= 1'b0;
         else if (side_req)
            pend_side <= 1'b1;

         if (emg && state == PED_WALK)
            pend_ped <= 1'b1;
         else if (enter_ped && !emg)
            pend_ped <= 1'b0;
         else if (ped_req)
            pend_ped <= 1'b1;

         if (enter_side && !emg)
            last_served <= SRV_SIDE;
         else if (enter_ped && !emg)
            last_served <= SRV_PED;

         // Registered so the pulse lines up with the first cycle of the grant.
         side_ack <= enter_side;
         ped_ack  <= enter_ped;
      end
   end

   // Next-state selection.
   always_comb begin
      nxt = state;
      unique case (state)
         MAIN_G:   if (!emg && timer >= MIN_G_LAST && (pend_side || pend_ped))
                      nxt = MAIN_Y;
         MAIN_Y:   if (timer == YEL_LAST) nxt = AR1;
         // Side is granted unless pedestrians are also waiting and side went last.
         AR1:      if (timer == AR_LAST)
                      nxt = (pend_side && (!pend_ped || last_served == SRV_PED))
                            ? SIDE_G : PED_WALK;
         SIDE_G:   if (emg || timer == SIDE_G_LAST) nxt = SIDE_Y;
         SIDE_Y:   if (timer == YEL_LAST) nxt = AR2;
         PED_WALK: if (emg || timer == WALK_LAST) nxt = PED_CLR;
         PED_CLR:  if (timer == PCLR_LAST) nxt = AR2;
         AR2:      if (timer == AR_LAST) nxt = MAIN_G;
         default:  nxt = MAIN_G;
      endcase
   end

   // Moore lamp decode: exactly one lamp lit per road, red unless granted.
   always_comb begin
      m_red    = 1'b1;
      m_yellow = 1'b0;
      m_green  = 1'b0;
      s_red    = 1'b1;
      s_yellow = 1'b0;
      s_green  = 1'b0;
      walk     = 1'b0;
      unique case (state)
         MAIN_G:   begin m_red = 1'b0; m_green  = 1'b1; end
         MAIN_Y:   begin m_red = 1'b0; m_yellow = 1'b1; end
         SIDE_G:   begin s_red = 1'b0; s_green  = 1'b1; end
         SIDE_Y:   begin s_red = 1'b0; s_yellow = 1'b1; end
         PED_WALK: walk = 1'b1;
         default:  ;
      endcase
      dont_walk = !walk;
      phase     = state;
   end

endmodule
